mem_arbiter: RTL and testbench

Shares the single-port 16 KB on-chip RAM between the 8086 CPU core and the video fetch unit, and converts the CPU's raw write strobe into a properly sequenced RAM write. It sits between the CPU bus (20-bit address, 8-bit data), the video character/attribute fetcher and the `mem_ram16k` instance, adding a ready handshake so the CPU stalls while video owns the RAM. CPU accesses outside the RAM window are decoded here and never reach the RAM.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 566 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the RAM.
// slave: arbiter side. master: CPU, video fetcher and RAM side.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_ready;

  logic        vid_req;
  logic [13:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_ack;

  logic [13:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_wren;
  logic [7:0]  ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_dout,
    output cpu_din, cpu_ready,
    input  vid_req, vid_addr,
    output vid_data, vid_ack,
    output ram_addr, ram_wdata, ram_wren,
    input  ram_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_dout,
    input  cpu_din, cpu_ready,
    output vid_req, vid_addr,
    input  vid_data, vid_ack,
    input  ram_addr, ram_wdata, ram_wren,
    output ram_q
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the 16 KB single-port RAM between the 8086 CPU and video fetch.
// Ports: clk, reset (sync, active high), bus (mem_arbiter_if.slave):
//   cpu_*  CPU byte bus with ready handshake (20-bit addr, 8-bit data)
//   vid_*  video read port with ack handshake (14-bit addr)
//   ram_*  registered RAM address/write controls, ram_q 1-cycle latency
// Option: define MEM_ARB_ROMPROT_EN to drop CPU writes to the top 1 KB.
module mem_arbiter #(
  parameter logic [19:0] RAM_BASE  = 20'h00000,
  parameter int unsigned VID_BURST = 4
) (
  input  logic   clk,
  input  logic   reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = ($clog2(VID_BURST + 1) > 3) ?
                      $clog2(VID_BURST + 1) : 3;
  localparam logic [CW-1:0] BMAX = CW'(VID_BURST);

  typedef enum logic [2:0] {
    IDLE,
    V_ADDR,
    V_DATA,
    C_ADDR,
    C_DATA,
    C_WR
  } state_t;

  state_t        state;
  logic [CW-1:0] burst_cnt;
  logic          cpu_ready_q;
  logic          vid_ack_q;
  logic          ram_wren_q;
  logic [7:0]    cpu_din_q;
  logic [7:0]    vid_data_q;
  logic [13:0]   ram_addr_q;
  logic [7:0]    ram_wdata_q;

  logic cpu_pend;
  logic vid_pend;
  logic vid_go;
  logic in_win;
  logic rom_hit;
  logic cpu_local;

  // A requester whose completion pulse is high this cycle is not
  // pending, so the ack cycle can only go to the other side.
  assign cpu_pend = bus.cpu_req & ~cpu_ready_q;
  assign vid_pend = bus.vid_req & ~vid_ack_q;
  assign vid_go   = vid_pend &
                    ~(cpu_pend & (burst_cnt == BMAX));
  assign in_win   = bus.cpu_addr[19:14] == RAM_BASE[19:14];

`ifdef MEM_ARB_ROMPROT_EN
  assign rom_hit = bus.cpu_addr[13:10] == 4'hF;
`else
  assign rom_hit = 1'b0;
`endif

  // Completed in IDLE without touching the RAM.
  assign cpu_local = ~in_win | (bus.cpu_we & rom_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      cpu_ready_q <= 1'b0;
      vid_ack_q   <= 1'b0;
      ram_wren_q  <= 1'b0;
      cpu_din_q   <= 8'hFF;
      vid_data_q  <= 8'hFF;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      vid_ack_q   <= 1'b0;
      ram_wren_q  <= 1'b0;
      if (!bus.cpu_req) begin
        burst_cnt <= '0;
      end
      unique case (state)
        IDLE: begin
          if (vid_go) begin
            state      <= V_ADDR;
            ram_addr_q <= bus.vid_addr;
            if (cpu_pend && burst_cnt != BMAX) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (cpu_pend) begin
            burst_cnt <= '0;
            if (cpu_local) begin
              cpu_ready_q <= 1'b1;
              if (!bus.cpu_we) begin
                cpu_din_q <= 8'hFF;
              end
            end else if (bus.cpu_we) begin
              state       <= C_WR;
              ram_addr_q  <= bus.cpu_addr[13:0];
              ram_wdata_q <= bus.cpu_dout;
              ram_wren_q  <= 1'b1;
            end else begin
              state      <= C_ADDR;
              ram_addr_q <= bus.cpu_addr[13:0];
            end
          end
        end
        V_ADDR: state <= V_DATA;
        V_DATA: begin
          state      <= IDLE;
          vid_data_q <= bus.ram_q;
          vid_ack_q  <= 1'b1;
        end
        C_ADDR: state <= C_DATA;
        C_DATA: begin
          state       <= IDLE;
          cpu_din_q   <= bus.ram_q;
          cpu_ready_q <= 1'b1;
        end
        C_WR: begin
          state       <= IDLE;
          cpu_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_din   = cpu_din_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked against a latency-based transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int VB = 4;
`ifdef MEM_ARB_ROMPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;

  mem_arbiter_if bus();

  mem_arbiter #(
    .RAM_BASE (20'h00000),
    .VID_BURST(VB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  // RAM: synchronous read, one cycle latency, preloaded with init_val.
  logic [7:0] ram   [16384];
  bit         ram_v [16384];
  always @(posedge clk) begin
    if (bus.ram_wren) begin
      ram[bus.ram_addr]   <= bus.ram_wdata;
      ram_v[bus.ram_addr] <= 1'b1;
    end
    bus.ram_q <= ram_v[bus.ram_addr] ?
                 ram[bus.ram_addr] : init_val(bus.ram_addr);
  end

  // Reference model: one owner at a time, a countdown of the access
  // latency, and a shadow memory updated when a write is accepted.
  logic [7:0]  sh   [16384];
  bit          sh_v [16384];
  int          m_busy;
  int          m_who;
  int          m_burst;
  logic [7:0]  m_cap;
  logic        m_rdy, m_ack, m_wren;
  logic [7:0]  m_din, m_vdat, m_wdata;
  logic [13:0] m_addr;

  function automatic logic [7:0] peek(logic [13:0] a);
    return sh_v[a] ? sh[a] : init_val(a);
  endfunction

  always @(posedge clk) begin : model
    logic        cp, vp, vg, win, prot, nr, na;
    logic [13:0] a;
    if (reset) begin
      m_busy  = 0;
      m_who   = 0;
      m_burst = 0;
      m_rdy   = 1'b0;
      m_ack   = 1'b0;
      m_wren  = 1'b0;
      m_din   = 8'hFF;
      m_vdat  = 8'hFF;
      m_addr  = '0;
      m_wdata = '0;
    end else begin
      nr     = 1'b0;
      na     = 1'b0;
      m_wren = 1'b0;
      cp     = bus.cpu_req && !m_rdy;
      vp     = bus.vid_req && !m_ack;
      a      = bus.cpu_addr[13:0];
      win    = bus.cpu_addr[19:14] == 6'd0;
      prot   = PROT && (a >= 14'h3C00);
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          if (m_who == 0) begin
            na     = 1'b1;
            m_vdat = m_cap;
          end else begin
            nr = 1'b1;
            if (m_who == 1) m_din = m_cap;
          end
        end
      end else begin
        vg = vp && !(cp && m_burst == VB);
        if (vg) begin
          m_busy = 2;
          m_who  = 0;
          m_addr = bus.vid_addr;
          m_cap  = peek(bus.vid_addr);
          if (cp && m_burst < VB) m_burst = m_burst + 1;
        end else if (cp) begin
          m_burst = 0;
          if (!win || (bus.cpu_we && prot)) begin
            nr = 1'b1;
            if (!bus.cpu_we) m_din = 8'hFF;
          end else if (bus.cpu_we) begin
            m_busy  = 1;
            m_who   = 2;
            m_addr  = a;
            m_wdata = bus.cpu_dout;
            m_wren  = 1'b1;
            sh[a]   = bus.cpu_dout;
            sh_v[a] = 1'b1;
          end else begin
            m_busy = 2;
            m_who  = 1;
            m_addr = a;
            m_cap  = peek(a);
          end
        end
      end
      if (!bus.cpu_req) m_burst = 0;
      m_rdy = nr;
      m_ack = na;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [19:0] rnd_cpu_addr();
    int          r;
    logic [13:0] off;
    r   = $urandom_range(0, 9);
    off = {4'($urandom), 4'h0, 6'($urandom)};
    if (r < 2) return {6'($urandom_range(1, 63)), off};
    if (r < 4) return {6'h00, 4'hF, off[9:0]};
    return {6'h00, off};
  endfunction

  task automatic test_reset();
    int k;
    reset        = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 20'h00010;
    bus.cpu_dout = 8'h00;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.cpu_ready, bus.vid_ack, bus.ram_wren} !== 3'b000 ||
          bus.cpu_din !== 8'hFF || bus.vid_data !== 8'hFF ||
          bus.ram_addr !== 14'h0 || bus.ram_wdata !== 8'h00) begin
        failures++;
        $display("FAIL reset_values cyc=%0d rdy=%b ack=%b wren=%b din=%h vdat=%h addr=%h wd=%h exp 0 0 0 ff ff 0000 00",
                 cyc, bus.cpu_ready, bus.vid_ack, bus.ram_wren,
                 bus.cpu_din, bus.vid_data, bus.ram_addr,
                 bus.ram_wdata);
      end
    end
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      tick();
      if (bus.cpu_ready || bus.vid_ack) k = i;
    end
    checks++;
    if (k != 3 || bus.vid_ack !== 1'b1 || bus.cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_ack got_tick=%0d ack=%b rdy=%b exp tick=3 ack=1 rdy=0",
               k, bus.vid_ack, bus.cpu_ready);
    end
    checks++;
    if (bus.vid_data !== init_val(14'h0200)) begin
      failures++;
      $display("FAIL first_vid_data got=%h exp=%h",
               bus.vid_data, init_val(14'h0200));
    end
    bus.vid_req = 1'b0;
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      tick();
      if (bus.cpu_ready) k = i;
    end
    checks++;
    if (k != 3 || bus.cpu_din !== init_val(14'h0010)) begin
      failures++;
      $display("FAIL cpu_after_vid tick=%0d din=%h exp tick=3 din=%h",
               k, bus.cpu_din, init_val(14'h0010));
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int k, nw;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 20'h00123;
    bus.cpu_dout = 8'hA5;
    k  = 0;
    nw = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      tick();
      if (bus.ram_wren) begin
        nw++;
        checks++;
        if (bus.ram_addr !== 14'h0123 || bus.ram_wdata !== 8'hA5) begin
          failures++;
          $display("FAIL wr_bus addr=%h wd=%h exp 0123 a5",
                   bus.ram_addr, bus.ram_wdata);
        end
      end
      if (bus.cpu_ready) k = i;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (k != 2 || nw != 1) begin
      failures++;
      $display("FAIL wr_timing tick=%0d wren_cycles=%0d exp 2 1", k, nw);
    end
    tick();
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    k  = 0;
    nw = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      tick();
      if (bus.ram_wren) nw++;
      if (bus.cpu_ready) k = i;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (k != 3 || nw != 0 || bus.cpu_din !== 8'hA5) begin
      failures++;
      $display("FAIL rd_back tick=%0d wren=%0d din=%h exp 3 0 a5",
               k, nw, bus.cpu_din);
    end
    tick();
  endtask

  task automatic test_out_of_window();
    int k, bad;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 20'h40000;
    k   = 0;
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.ram_wren || bus.ram_addr !== 14'h0123) bad++;
      if (bus.cpu_ready && k == 0) begin
        k = i;
        bus.cpu_req = 1'b0;
        checks++;
        if (bus.cpu_din !== 8'hFF) begin
          failures++;
          $display("FAIL oow_rd_data got=%h exp=ff", bus.cpu_din);
        end
      end
    end
    checks++;
    if (k != 1 || bad != 0) begin
      failures++;
      $display("FAIL oow_rd tick=%0d ram_touch=%0d exp 1 0", k, bad);
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 20'hC1234;
    bus.cpu_dout = 8'h77;
    k   = 0;
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.ram_wren) bad++;
      if (bus.cpu_ready && k == 0) begin
        k = i;
        bus.cpu_req = 1'b0;
      end
    end
    checks++;
    if (k != 1 || bad != 0 || bus.cpu_din !== 8'hFF) begin
      failures++;
      $display("FAIL oow_wr tick=%0d wren=%0d din=%h exp 1 0 ff",
               k, bad, bus.cpu_din);
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 20'h01234;
    k = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      tick();
      if (bus.cpu_ready) k = i;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (k != 3 || bus.cpu_din !== init_val(14'h1234)) begin
      failures++;
      $display("FAIL oow_alias tick=%0d din=%h exp 3 %h",
               k, bus.cpu_din, init_val(14'h1234));
    end
    tick();
  endtask

  task automatic test_rom_protect();
    int         k, nw, exp_k, exp_nw;
    logic [7:0] exp_d;
    exp_k  = PROT ? 1 : 2;
    exp_nw = PROT ? 0 : 1;
    exp_d  = PROT ? init_val(14'h3C10) : 8'h55;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 20'h03C10;
    bus.cpu_dout = 8'h55;
    k  = 0;
    nw = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      tick();
      if (bus.ram_wren) nw++;
      if (bus.cpu_ready) k = i;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (k != exp_k || nw != exp_nw) begin
      failures++;
      $display("FAIL rom_wr tick=%0d wren=%0d exp %0d %0d",
               k, nw, exp_k, exp_nw);
    end
    tick();
    bus.cpu_req = 1'b1;
    bus.cpu_we  = 1'b0;
    k = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      tick();
      if (bus.cpu_ready) k = i;
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (k != 3 || bus.cpu_din !== exp_d) begin
      failures++;
      $display("FAIL rom_rd tick=%0d din=%h exp 3 %h",
               k, bus.cpu_din, exp_d);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int nr;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 20'h00456;
    bus.cpu_dout = 8'h3E;
    tick();
    checks++;
    if (bus.ram_wren !== 1'b1) begin
      failures++;
      $display("FAIL rst_wr_start wren=%b exp=1", bus.ram_wren);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.ram_wren !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_wr_abort wren=%b rdy=%b exp 0 0",
               bus.ram_wren, bus.cpu_ready);
    end
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    nr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_ready || bus.ram_wren) nr++;
    end
    checks++;
    if (nr != 0) begin
      failures++;
      $display("FAIL rst_wr_after pulses=%0d exp=0", nr);
    end
  endtask

  task automatic test_contention();
    int waitc, n_cpu, n_vid;
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'($urandom);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = {6'h00, 14'($urandom)};
    waitc = 0;
    n_cpu = 0;
    n_vid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      waitc++;
      checks += 2;
      if (bus.vid_ack !== m_ack) begin
        failures++;
        $display("FAIL cont_vid_ack cyc=%0d got=%b exp=%b",
                 cyc, bus.vid_ack, m_ack);
      end
      if (bus.cpu_ready !== m_rdy) begin
        failures++;
        $display("FAIL cont_cpu_ready cyc=%0d got=%b exp=%b",
                 cyc, bus.cpu_ready, m_rdy);
      end
      if (bus.vid_ack) begin
        n_vid++;
        checks++;
        if (bus.vid_data !== m_vdat) begin
          failures++;
          $display("FAIL cont_vid_data got=%h exp=%h",
                   bus.vid_data, m_vdat);
        end
        bus.vid_addr = 14'($urandom);
      end
      if (bus.cpu_ready) begin
        n_cpu++;
        checks += 2;
        if (waitc > VB * 3 + 3) begin
          failures++;
          $display("FAIL cont_cpu_wait got=%0d max=%0d",
                   waitc, VB * 3 + 3);
        end
        if (bus.cpu_din !== m_din) begin
          failures++;
          $display("FAIL cont_cpu_din got=%h exp=%h",
                   bus.cpu_din, m_din);
        end
        waitc        = 0;
        bus.cpu_addr = {6'h00, 14'($urandom)};
      end
    end
    checks++;
    if (n_cpu < 2 || n_vid < 2) begin
      failures++;
      $display("FAIL cont_progress cpu=%0d vid=%0d exp >=2 each",
               n_cpu, n_vid);
    end
    for (int i = 0; i < 20 && (bus.cpu_req || bus.vid_req); i++) begin
      tick();
      if (bus.cpu_ready) bus.cpu_req = 1'b0;
      if (bus.vid_ack) bus.vid_req = 1'b0;
    end
    checks++;
    if (bus.cpu_req || bus.vid_req) begin
      failures++;
      $display("FAIL cont_drain cpu_req=%b vid_req=%b exp 0 0",
               bus.cpu_req, bus.vid_req);
    end
    tick();
  endtask

  task automatic test_random();
    int n_rdy, n_ack;
    n_rdy = 0;
    n_ack = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      checks += 7;
      if (bus.cpu_ready !== m_rdy) begin
        failures++;
        $display("FAIL rnd_cpu_ready cyc=%0d got=%b exp=%b",
                 cyc, bus.cpu_ready, m_rdy);
      end
      if (bus.vid_ack !== m_ack) begin
        failures++;
        $display("FAIL rnd_vid_ack cyc=%0d got=%b exp=%b",
                 cyc, bus.vid_ack, m_ack);
      end
      if (bus.ram_wren !== m_wren) begin
        failures++;
        $display("FAIL rnd_ram_wren cyc=%0d got=%b exp=%b",
                 cyc, bus.ram_wren, m_wren);
      end
      if (bus.ram_addr !== m_addr) begin
        failures++;
        $display("FAIL rnd_ram_addr cyc=%0d got=%h exp=%h",
                 cyc, bus.ram_addr, m_addr);
      end
      if (bus.ram_wdata !== m_wdata) begin
        failures++;
        $display("FAIL rnd_ram_wdata cyc=%0d got=%h exp=%h",
                 cyc, bus.ram_wdata, m_wdata);
      end
      if (bus.cpu_din !== m_din) begin
        failures++;
        $display("FAIL rnd_cpu_din cyc=%0d got=%h exp=%h",
                 cyc, bus.cpu_din, m_din);
      end
      if (bus.vid_data !== m_vdat) begin
        failures++;
        $display("FAIL rnd_vid_data cyc=%0d got=%h exp=%h",
                 cyc, bus.vid_data, m_vdat);
      end
      if (bus.cpu_ready) n_rdy++;
      if (bus.vid_ack) n_ack++;
      if (!bus.cpu_req || bus.cpu_ready) begin
        if ($urandom_range(0, 99) < 45) begin
          bus.cpu_req  = 1'b1;
          bus.cpu_we   = 1'($urandom);
          bus.cpu_addr = rnd_cpu_addr();
          bus.cpu_dout = 8'($urandom);
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
      if (!bus.vid_req || bus.vid_ack) begin
        if ($urandom_range(0, 99) < 40) begin
          bus.vid_req  = 1'b1;
          bus.vid_addr = {4'($urandom), 4'h0, 6'($urandom)};
        end else begin
          bus.vid_req = 1'b0;
        end
      end
    end
    checks++;
    if (n_rdy < 20 || n_ack < 20) begin
      failures++;
      $display("FAIL rnd_progress cpu=%0d vid=%0d exp >=20 each",
               n_rdy, n_ack);
    end
    for (int i = 0; i < 20 && (bus.cpu_req || bus.vid_req); i++) begin
      tick();
      if (bus.cpu_ready) bus.cpu_req = 1'b0;
      if (bus.vid_ack) bus.vid_req = 1'b0;
    end
    checks++;
    if (bus.cpu_req || bus.vid_req) begin
      failures++;
      $display("FAIL rnd_drain cpu_req=%b vid_req=%b exp 0 0",
               bus.cpu_req, bus.vid_req);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d exp finish before limit", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_write_read();
    test_out_of_window();
    test_rom_protect();
    test_reset_mid_write();
    test_contention();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
